// File: rtl/xadc_multi_reader.sv
// xadc_multi_reader: round-robin XADC DRP reader, mV scaling and BCD conversion.
// Optional macro XADC_RD_AVG_EN averages each sample with the previous one per channel.
module xadc_multi_reader #(
    parameter int               NCH      = 13,
    parameter logic [8*NCH-1:0] CH_ADDRS = {NCH{8'h00}},
    parameter logic [15:0]      MUL      = 16'd7629,
    parameter int               SHIFT    = 13,
    parameter int               TIMEOUT  = 255,
    parameter int               FREE_RUN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eoc,
    output logic              den,
    output logic              dwe,
    output logic [6:0]        daddr,
    input  logic              drdy,
    input  logic [15:0]       do_in,
    output logic [16*NCH-1:0] bcd_all,
    output logic              upd_valid,
    output logic [3:0]        upd_ch,
    output logic              err_valid,
    output logic              sweep_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SCALE,
        S_BCD,
        S_STORE,
        S_NEXT
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  idx_inc;
    logic [9:0]  tmo_cnt;
    logic [3:0]  bit_cnt;
    logic [11:0] raw;
    logic [11:0] raw_in;
    logic [11:0] sample;
    logic [29:0] dd;
    logic [29:0] dd_adj;
    logic [29:0] dd_nxt;
    logic [27:0] prod;
    logic [27:0] mv_full;
    logic [13:0] mv;
    logic        eoc_q;
    logic        start;
    logic        last;
    logic        unused_bits;

    assign dwe     = 1'b0;
    assign sample  = do_in[15:4];
    assign idx_inc = idx + 4'd1;
    assign last    = (idx == 4'(NCH - 1));
    assign start   = (FREE_RUN != 0) || (eoc && !eoc_q);

    assign prod    = 28'(raw) * 28'(MUL);
    assign mv_full = prod >> SHIFT;
    assign mv      = (mv_full > 28'd9999) ? 14'd9999 : mv_full[13:0];

    // one shift-add-3 step: digits sit in dd[29:14], binary in dd[13:0]
    always_comb begin
        dd_adj = dd;
        for (int d = 0; d < 4; d++) begin
            if (dd_adj[14+4*d +: 4] >= 4'd5)
                dd_adj[14+4*d +: 4] = dd_adj[14+4*d +: 4] + 4'd3;
        end
        dd_nxt = {dd_adj[28:0], 1'b0};
    end

`ifdef XADC_RD_AVG_EN
    logic [11:0] prev [16];
    logic [12:0] sum;
    logic        unused_avg;

    assign sum        = 13'(prev[idx]) + 13'(sample);
    assign raw_in     = sum[12:1];
    assign unused_avg = sum[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                prev[i] <= 12'd0;
        end else if (state == S_WAIT && drdy) begin
            prev[idx] <= sample;
        end
    end
`else
    assign raw_in = sample;
`endif

    assign unused_bits = ^{do_in[3:0], dd_adj[29]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            tmo_cnt    <= 10'd0;
            bit_cnt    <= 4'd0;
            raw        <= 12'd0;
            dd         <= 30'd0;
            eoc_q      <= 1'b0;
            den        <= 1'b0;
            daddr      <= 7'd0;
            bcd_all    <= '0;
            upd_valid  <= 1'b0;
            upd_ch     <= 4'd0;
            err_valid  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            eoc_q      <= eoc;
            den        <= 1'b0;
            upd_valid  <= 1'b0;
            err_valid  <= 1'b0;
            sweep_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_REQ;
                        den   <= 1'b1;
                        daddr <= CH_ADDRS[8*idx +: 7];
                    end
                end
                S_REQ: begin
                    tmo_cnt <= 10'd0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (drdy) begin
                        raw   <= raw_in;
                        state <= S_SCALE;
                    end else if (tmo_cnt + 10'd1 == 10'(TIMEOUT)) begin
                        err_valid <= 1'b1;
                        state     <= S_NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                S_SCALE: begin
                    dd      <= {16'd0, mv};
                    bit_cnt <= 4'd0;
                    state   <= S_BCD;
                end
                S_BCD: begin
                    dd      <= dd_nxt;
                    bit_cnt <= bit_cnt + 4'd1;
                    // the final shift lands straight in the channel slice
                    if (bit_cnt == 4'd13) begin
                        bcd_all[16*idx +: 16] <= dd_nxt[29:14];
                        upd_valid             <= 1'b1;
                        upd_ch                <= idx;
                        state                 <= S_STORE;
                    end
                end
                S_STORE: begin
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (last) begin
                        idx        <= 4'd0;
                        sweep_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        idx   <= idx_inc;
                        den   <= 1'b1;
                        daddr <= CH_ADDRS[8*idx_inc +: 7];
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
